// File: rtl/cpu_writeback_pkg.sv
// Shared opcode header for the writeback stage: branch codes, push-bit
// positions, FSM state encodings and stack limits.
package cpu_writeback_pkg;

  typedef enum logic [1:0] {
    UC_BR_NONE = 2'd0,
    UC_BR_JMP  = 2'd1,
    UC_BR_COND = 2'd2,
    UC_BR_RET  = 2'd3
  } br_code_e;

  localparam int PUSH_R1_BIT  = 2;
  localparam int PUSH_R0_BIT  = 1;
  localparam int PUSH_ALU_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH2 = 2'd1,
    PUSH3 = 2'd2
  } wb_state_e;

  localparam logic [10:0] SP_MAX = 11'd2047;

endpackage

// File: rtl/cpu_writeback.sv
// Writeback stage: pops, up to three stack pushes (one per cycle, ALU result last)
// and branch resolution. First push/kill appear the cycle after accept; stall_4a holds upstream.
module cpu_writeback
  import cpu_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        alu__cond_3a,
  input  logic [31:0] alu__out_3a,
  input  logic [1:0]  c__branch_3a,
  input  logic [2:0]  c__to_push_3a,
  input  logic [31:0] pc_3a,
  input  logic [34:0] r0_3a,
  input  logic [34:0] r1_3a,
  input  logic [10:0] st__to_pop_3a,
  input  logic [10:0] st__saved_pc_3a,
  output logic        kill_4a,
  output logic [31:0] pc_next_4a,
  output logic        stall_4a,
  output logic        stk_we,
  output logic [10:0] stk_waddr,
  output logic [34:0] stk_wdata,
  output logic [10:0] sp_4a,
  output logic        err_underflow,
  output logic        err_overflow
);

  wb_state_e   state;
  logic [34:0] hold_a, hold_b;
  logic        hold_b_vld;

  logic        accept, underflow, taken;
  logic [10:0] sp_pop, push_base, sp_next;
  logic [31:0] target;
  logic [1:0]  n_push;
  logic [34:0] slot0, slot1, slot2, push_val;
  logic [34:0] cand [3];
  logic [2:0]  sel;
  logic        push_go, push_ok;

  logic        pc_dbg_unused;
  assign pc_dbg_unused = ^pc_3a;

  assign accept   = (state == IDLE) && !kill_4a;
  assign stall_4a = (state != IDLE);

  assign underflow = (st__to_pop_3a > sp_4a);
  assign sp_pop    = underflow ? 11'd0 : sp_4a - st__to_pop_3a;

  // Compact the requested pushes into issue order r1, r0, alu.
  always_comb begin
    cand[0] = r1_3a;
    cand[1] = r0_3a;
    cand[2] = {3'b000, alu__out_3a};
    sel     = {c__to_push_3a[PUSH_ALU_BIT], c__to_push_3a[PUSH_R0_BIT], c__to_push_3a[PUSH_R1_BIT]};
    slot0   = '0;
    slot1   = '0;
    slot2   = '0;
    n_push  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (sel[i]) begin
        if (n_push == 2'd0)      slot0 = cand[i];
        else if (n_push == 2'd1) slot1 = cand[i];
        else                     slot2 = cand[i];
        n_push = n_push + 2'd1;
      end
    end
  end

  always_comb begin
    taken  = 1'b0;
    target = alu__out_3a;
    case (br_code_e'(c__branch_3a))
      UC_BR_JMP:  taken = 1'b1;
      UC_BR_COND: taken = alu__cond_3a;
      UC_BR_RET: begin
        taken  = 1'b1;
        target = {21'b0, st__saved_pc_3a};
      end
      default:    taken = 1'b0;
    endcase
  end

  // Pushes issued from the accept cycle start at the post-pop pointer.
  always_comb begin
    push_go   = 1'b0;
    push_val  = hold_a;
    push_base = sp_4a;
    case (state)
      IDLE: begin
        if (accept) begin
          push_go   = (n_push != 2'd0);
          push_val  = slot0;
          push_base = sp_pop;
        end
      end
      PUSH2:   push_go = 1'b1;
      PUSH3: begin
        push_go  = 1'b1;
        push_val = hold_b;
      end
      default: push_go = 1'b0;
    endcase
  end

  assign push_ok = push_go && (push_base != SP_MAX);
  assign sp_next = push_ok ? push_base + 11'd1 : push_base;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      hold_a        <= '0;
      hold_b        <= '0;
      hold_b_vld    <= 1'b0;
      kill_4a       <= 1'b0;
      pc_next_4a    <= '0;
      stk_we        <= 1'b0;
      stk_waddr     <= '0;
      stk_wdata     <= '0;
      sp_4a         <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      stk_we  <= push_ok;
      sp_4a   <= sp_next;
      kill_4a <= accept && taken;
      if (push_ok) begin
        stk_waddr <= push_base;
        stk_wdata <= push_val;
      end
      if (push_go && !push_ok) err_overflow  <= 1'b1;
      if (accept && underflow) err_underflow <= 1'b1;
      if (accept && taken)     pc_next_4a    <= target;
      case (state)
        IDLE: begin
          if (accept && n_push >= 2'd2) begin
            state      <= PUSH2;
            hold_a     <= slot1;
            hold_b     <= slot2;
            hold_b_vld <= (n_push == 2'd3);
          end
        end
        PUSH2:   state <= hold_b_vld ? PUSH3 : IDLE;
        PUSH3:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_writeback.md
CPU_WRITEBACK -- requirements
Module: cpu_writeback

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge clock.
REQ-002 SHALL have port rst_b, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have inputs alu__cond_3a (1), alu__out_3a (32), c__branch_3a (2), c__to_push_3a (3), pc_3a (32), r0_3a (35), r1_3a (35), st__to_pop_3a (11) and st__saved_pc_3a (11), all driven by the execute-stage registers.
REQ-004 SHALL have output kill_4a, 1, registered: squash signal to the execute and earlier stages.
REQ-005 SHALL have output pc_next_4a, 32, registered: redirect target, valid while kill_4a=1.
REQ-006 SHALL have output stall_4a, 1: when high, upstream holds all _3a registers.
REQ-007 SHALL have outputs stk_we (1), stk_waddr (11) and stk_wdata (35), all registered: the single stack-RAM write port.
REQ-008 SHALL have output sp_4a, 11, registered: next-free stack pointer.
REQ-009 SHALL have outputs err_underflow and err_overflow, 1 each, sticky.

Function
REQ-010 SHALL accept the _3a inputs only in state IDLE with kill_4a=0; otherwise the inputs are ignored.
REQ-011 SHALL treat the cycle as a bubble when kill_4a=1: no pops, no pushes, no branch.
REQ-012 SHALL, on accept, set sp = sp - st__to_pop_3a; if st__to_pop_3a > sp, it SHALL set sp=0 and err_underflow=1.
REQ-013 SHALL define c__to_push_3a bits as bit2 push r1_3a, bit1 push r0_3a, bit0 push {3'b000, alu__out_3a}.
REQ-014 SHALL perform pushes in the order r1, r0, alu, so that the ALU result ends on top.
REQ-015 SHALL apply pops before pushes within the same instruction.
REQ-016 SHALL perform each push as one cycle: stk_we=1, stk_waddr=sp, stk_wdata=value, then sp = sp + 1.
REQ-017 SHALL perform the first push in the accept cycle, with its outputs visible the next cycle.
REQ-018 SHALL latch any remaining pushes into internal holding registers on accept.
REQ-019 SHALL use FSM states IDLE, PUSH2 and PUSH3.
REQ-020 SHALL transition IDLE->PUSH2 on accept with 2 pushes; PUSH2->IDLE after issuing it.
REQ-021 SHALL transition IDLE->PUSH2 on accept with 3 pushes; PUSH2->PUSH3->IDLE.
REQ-022 SHALL drive stall_4a = (state != IDLE), decoded from registered state only.
REQ-023 SHALL suppress the write and set err_overflow=1 for a push at sp=2047; sp SHALL stay 2047.
REQ-024 SHALL evaluate the branch on accept, where c__branch_3a is 0 none, 1 jump to alu__out_3a, 2 jump to alu__out_3a if alu__cond_3a, 3 return to {21'b0, st__saved_pc_3a}.
REQ-025 SHALL, on a taken branch, assert kill_4a=1 for exactly the next cycle with pc_next_4a=target; pc_3a is otherwise unused except for debug.
REQ-026 SHALL process a taken branch with multi-push concurrently: kill_4a pulses while the FSM continues pushing.
REQ-027 SHALL hold stk_we=0 in every cycle without a push.
REQ-028 SHALL leave stk_waddr and stk_wdata holding their last values when stk_we=0.

Reset
REQ-029 SHALL, on rst_b=0, immediately force state=IDLE and set all outputs and holding registers to 0: kill_4a, pc_next_4a, stk_we, stk_waddr, stk_wdata, sp_4a, err_underflow, err_overflow.
REQ-030 SHALL discard any pending pushes when reset is asserted mid-sequence.
REQ-031 SHALL clear err flags only by reset.

Structure
REQ-032 SHALL take the branch codes (UC_BR_NONE/JMP/COND/RET), the push-bit positions and the FSM state encodings from the shared opcode header.
REQ-033 SHALL use no sub-module; push-count and next-value selection are local combinational logic.

Verification
REQ-034 SHALL cover single push: sp=5, to_push=3'b001, alu__out=0x1234 -> next cycle stk_we=1, waddr=5, wdata=0x1234, sp=6, stall_4a=0.
REQ-035 SHALL cover triple push: sp=10, to_pop=1, to_push=3'b111, r1=A, r0=B, alu=C -> writes at 9, 10, 11 of A, B, C; stall_4a=1 for 2 cycles; final sp=12.
REQ-036 SHALL cover conditional branch: c__branch=2, alu__cond=1, alu__out=0x40 -> kill_4a=1 one cycle, pc_next_4a=0x40; with alu__cond=0 -> kill_4a stays 0.
REQ-037 SHALL cover the kill bubble: instruction with to_push=3'b001 presented in the cycle kill_4a=1 -> no write, sp unchanged.
REQ-038 SHALL cover boundaries: sp=2 with to_pop=3 -> sp=0 and err_underflow=1; sp=2047 with a push -> stk_we=0 and err_overflow=1.
REQ-039 SHALL cover reset mid-sequence: assert rst_b=0 during PUSH2 -> all outputs 0, state IDLE, no further writes after release.
